// File: rtl/noc_host_initiator.sv
// ----------------------------------------------------------------------------
// noc_host_initiator
//
// Host-side initiator for the byte-serial NoC device link. Accepts one 64-bit
// read or write request at a time, serialises it as a command byte, an
// address byte, a length byte and (for writes) eight payload bytes LSB-first.
// It then waits for the matching device response, checks it and returns read
// data together with an error code.
//
// Parameters:
//   TIMEOUT    cycles allowed in the response states before a timeout
//   LEN_BYTES  payload byte count carried in the length byte (64-bit word)
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = write, 0 = read
//   req_addr, req_wdata device address byte and write payload
//   rsp_valid           one-cycle completion pulse, no backpressure
//   rsp_rdata           read data (held until the next read completes)
//   rsp_err             0 ok, 1 device status, 2 protocol, 3 timeout
//   noc_to_dev_*        outbound byte stream (ctl=1 command/NOP, 0 payload)
//   noc_from_dev_*      inbound byte stream
// ----------------------------------------------------------------------------
module noc_host_initiator #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned LEN_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        noc_to_dev_ctl,
    output logic [7:0]  noc_to_dev_data,
    input  logic        noc_from_dev_ctl,
    input  logic [7:0]  noc_from_dev_data
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [2:0] OP_WR    = 3'b010;
    localparam logic [2:0] OP_RDRSP = 3'b011;
    localparam logic [2:0] OP_WRRSP = 3'b100;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_STAT  = 2'd1;
    localparam logic [1:0] ERR_PROTO = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    // Each TX_* state names the byte currently on the outbound registers.
    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_CMD,
        S_TX_ADDR,
        S_TX_LEN,
        S_TX_DATA,
        S_WAIT_RSP,
        S_RX_LEN,
        S_RX_DATA,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_write;
    logic [7:0]         r_addr;
    logic [63:0]        r_wdata;
    logic [2:0]         r_byte_cnt;
    logic [1:0]         r_status;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [63:0]        r_rsp_rdata;
    logic [1:0]         r_rsp_err;
    logic               r_tx_ctl;
    logic [7:0]         r_tx_data;

    logic [2:0]         w_rx_op;
    logic [1:0]         w_rx_stat;
    logic [2:0]         w_exp_op;
    logic [2:0]         w_cnt_nxt;
    logic               w_tmo_hit;

    assign w_rx_op   = noc_from_dev_data[7:5];
    assign w_rx_stat = noc_from_dev_data[1:0];
    assign w_exp_op  = r_write ? OP_WRRSP : OP_RDRSP;
    assign w_cnt_nxt = r_byte_cnt + 3'd1;
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign noc_to_dev_ctl  = r_tx_ctl;
    assign noc_to_dev_data = r_tx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_byte_cnt  <= '0;
            r_status    <= '0;
            r_tmo_cnt   <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
            r_tx_ctl    <= 1'b1;
            r_tx_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_tx_ctl    <= 1'b1;
                        r_tx_data   <= {(req_write ? OP_WR : OP_RD), 5'b00000};
                        r_state     <= S_TX_CMD;
                    end
                end

                S_TX_CMD: begin
                    r_tx_ctl  <= 1'b0;
                    r_tx_data <= r_addr;
                    r_state   <= S_TX_ADDR;
                end

                S_TX_ADDR: begin
                    r_tx_data <= 8'(LEN_BYTES);
                    r_state   <= S_TX_LEN;
                end

                S_TX_LEN: begin
                    if (r_write) begin
                        r_tx_data  <= r_wdata[7:0];
                        r_byte_cnt <= '0;
                        r_state    <= S_TX_DATA;
                    end else begin
                        r_tx_ctl  <= 1'b1;
                        r_tx_data <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT_RSP;
                    end
                end

                S_TX_DATA: begin
                    if (r_byte_cnt == 3'd7) begin
                        r_tx_ctl  <= 1'b1;
                        r_tx_data <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT_RSP;
                    end else begin
                        r_byte_cnt <= w_cnt_nxt;
                        r_tx_data  <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
                    end
                end

                S_WAIT_RSP: begin
                    if (w_tmo_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TMO;
                        r_state     <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (noc_from_dev_ctl && (w_rx_op != OP_NOP)) begin
                            if (w_rx_op == w_exp_op) begin
                                if (r_write) begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= (w_rx_stat != 2'b00) ? ERR_STAT : ERR_OK;
                                    r_state     <= S_DONE;
                                end else begin
                                    r_status <= w_rx_stat;
                                    r_state  <= S_RX_LEN;
                                end
                            end else begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= ERR_PROTO;
                                r_state     <= S_DONE;
                            end
                        end
                    end
                end

                S_RX_LEN: begin
                    if (w_tmo_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TMO;
                        r_state     <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (noc_from_dev_ctl || (noc_from_dev_data != 8'(LEN_BYTES))) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_PROTO;
                            r_state     <= S_DONE;
                        end else begin
                            r_byte_cnt <= '0;
                            r_state    <= S_RX_DATA;
                        end
                    end
                end

                // Bytes land straight in rsp_rdata so a truncated packet leaves
                // exactly the bytes already received updated.
                S_RX_DATA: begin
                    if (w_tmo_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TMO;
                        r_state     <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (noc_from_dev_ctl) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_PROTO;
                            r_state     <= S_DONE;
                        end else begin
                            r_rsp_rdata[{r_byte_cnt, 3'b000} +: 8] <= noc_from_dev_data;
                            if (r_byte_cnt == 3'd7) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= (r_status != 2'b00) ? ERR_STAT : ERR_OK;
                                r_state     <= S_DONE;
                            end else begin
                                r_byte_cnt <= w_cnt_nxt;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_host_initiator.sv
// ----------------------------------------------------------------------------
// tb_noc_host_initiator
//
// Directed bench for noc_host_initiator (TIMEOUT overridden to 16). Inputs are
// driven 1 ns after the rising edge and outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_noc_host_initiator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        noc_to_dev_ctl;
    logic [7:0]  noc_to_dev_data;
    logic        noc_from_dev_ctl;
    logic [7:0]  noc_from_dev_data;

    int unsigned n_checks;
    int unsigned n_errors;

    // Inbound byte script: bit 8 = ctl, bits 7:0 = data.
    logic [8:0] rx_q[$];

    noc_host_initiator #(
        .TIMEOUT   (16),
        .LEN_BYTES (8)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .noc_to_dev_ctl    (noc_to_dev_ctl),
        .noc_to_dev_data   (noc_to_dev_data),
        .noc_from_dev_ctl  (noc_from_dev_ctl),
        .noc_from_dev_data (noc_from_dev_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request and checks every outbound byte; returns in the first
    // WAIT_RSP cycle.
    task automatic send_req(input string tag, input logic wr, input logic [7:0] addr,
                            input logic [63:0] wdata);
        logic [8:0] exp_b[$];
        exp_b = {};
        exp_b.push_back({1'b1, (wr ? 8'h40 : 8'h20)});
        exp_b.push_back({1'b0, addr});
        exp_b.push_back({1'b0, 8'h08});
        if (wr) begin
            for (int i = 0; i < 8; i++) begin
                exp_b.push_back({1'b0, wdata[i*8 +: 8]});
            end
        end
        check_eq({tag, ".ready"}, 64'(req_ready), 64'h1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 8'hFF;
        req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        foreach (exp_b[i]) begin
            check_eq($sformatf("%s.b%0d", tag, i), {55'd0, noc_to_dev_ctl, noc_to_dev_data},
                     64'(exp_b[i]));
            tick();
        end
        check_eq({tag, ".nop"}, {55'd0, noc_to_dev_ctl, noc_to_dev_data}, 64'h100);
        check_eq({tag, ".busy"}, 64'(req_ready), 64'h0);
    endtask

    // Plays the inbound script, one byte per cycle, then returns the link to NOP.
    task automatic feed_rx();
        while (rx_q.size() > 0) begin
            {noc_from_dev_ctl, noc_from_dev_data} = rx_q.pop_front();
            tick();
        end
        noc_from_dev_ctl  = 1'b1;
        noc_from_dev_data = 8'h00;
    endtask

    // Called in the cycle the completion pulse is expected.
    task automatic expect_done(input string tag, input logic [1:0] err, input logic [63:0] rdata);
        check_eq({tag, ".valid"}, 64'(rsp_valid), 64'h1);
        check_eq({tag, ".err"}, 64'(rsp_err), 64'(err));
        check_eq({tag, ".rdata"}, rsp_rdata, rdata);
        check_eq({tag, ".ready_lo"}, 64'(req_ready), 64'h0);
        tick();
        check_eq({tag, ".valid_lo"}, 64'(rsp_valid), 64'h0);
        check_eq({tag, ".ready_hi"}, 64'(req_ready), 64'h1);
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        reset             = 1'b1;
        req_valid         = 1'b0;
        req_write         = 1'b0;
        req_addr          = 8'h00;
        req_wdata         = 64'h0;
        noc_from_dev_ctl  = 1'b1;
        noc_from_dev_data = 8'h00;

        tick();
        tick();
        check_eq("rst.ctl",   64'(noc_to_dev_ctl), 64'h1);
        check_eq("rst.data",  64'(noc_to_dev_data), 64'h0);
        check_eq("rst.valid", 64'(rsp_valid), 64'h0);
        check_eq("rst.rdata", rsp_rdata, 64'h0);
        check_eq("rst.err",   64'(rsp_err), 64'h0);
        check_eq("rst.ready", 64'(req_ready), 64'h1);
        reset = 1'b0;
        tick();

        // Write, ok response
        send_req("wr1", 1'b1, 8'h05, 64'h8877665544332211);
        rx_q = {9'h180};
        feed_rx();
        expect_done("wr1", 2'd0, 64'h0);

        // Read with NOP preamble, ok
        send_req("rd1", 1'b0, 8'h12, 64'h0);
        rx_q = {9'h100, 9'h100, 9'h160, 9'h008, 9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE,
                9'h078, 9'h056, 9'h034, 9'h012};
        feed_rx();
        expect_done("rd1", 2'd0, 64'h12345678DEADBEEF);

        // Read with device status error, data still captured
        send_req("rd_st", 1'b0, 8'h21, 64'h0);
        rx_q = {9'h161, 9'h008, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006,
                9'h007, 9'h008};
        feed_rx();
        expect_done("rd_st", 2'd1, 64'h0807060504030201);

        // Write with device status error; read data untouched
        send_req("wr_st", 1'b1, 8'h30, 64'h0F0E0D0C0B0A0908);
        rx_q = {9'h0AA, 9'h182};
        feed_rx();
        expect_done("wr_st", 2'd1, 64'h0807060504030201);

        // Read answered with a write response
        send_req("pe_op", 1'b0, 8'h40, 64'h0);
        rx_q = {9'h180};
        feed_rx();
        expect_done("pe_op", 2'd2, 64'h0807060504030201);

        // Bad length byte
        send_req("pe_len", 1'b0, 8'h41, 64'h0);
        rx_q = {9'h160, 9'h004};
        feed_rx();
        expect_done("pe_len", 2'd2, 64'h0807060504030201);

        // Truncated after three data bytes: only those bytes change
        send_req("pe_trunc", 1'b0, 8'h42, 64'h0);
        rx_q = {9'h160, 9'h008, 9'h0AA, 9'h0BB, 9'h0CC, 9'h160};
        feed_rx();
        expect_done("pe_trunc", 2'd2, 64'h0807060504CCBBAA);

        // Silent device: pulse exactly 16 cycles after WAIT_RSP entry
        send_req("tmo", 1'b0, 8'h50, 64'h0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check_eq($sformatf("tmo.quiet%0d", k), 64'(rsp_valid), 64'h0);
        end
        tick();
        expect_done("tmo", 2'd3, 64'h0807060504CCBBAA);

        // Asynchronous reset while payload byte 4 is on the link
        check_eq("rstmid.ready", 64'(req_ready), 64'h1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h77;
        req_wdata = 64'hF7F6F5F4F3F2F1F0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_eq("rstmid.b4", {55'd0, noc_to_dev_ctl, noc_to_dev_data}, 64'h0F4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid.ctl",   64'(noc_to_dev_ctl), 64'h1);
        check_eq("rstmid.data",  64'(noc_to_dev_data), 64'h0);
        check_eq("rstmid.valid", 64'(rsp_valid), 64'h0);
        check_eq("rstmid.ready", 64'(req_ready), 64'h1);
        check_eq("rstmid.rdata", rsp_rdata, 64'h0);
        check_eq("rstmid.err",   64'(rsp_err), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst.valid", 64'(rsp_valid), 64'h0);

        send_req("wr2", 1'b1, 8'h09, 64'hA7A6A5A4A3A2A1A0);
        rx_q = {9'h100, 9'h180};
        feed_rx();
        expect_done("wr2", 2'd0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_host_initiator.md
Name: noc_host_initiator

Overview:
- Host-side initiator for the byte-serial NoC device interface; it is the other end of the link that the device-side NoC interface terminates.
- Takes single 64-bit read/write requests from a bench or host controller.
- Serializes each request onto noc_to_dev_ctl/noc_to_dev_data, then collects and checks the device response on noc_from_dev_ctl/noc_from_dev_data.
- Returns read data plus an error code. One transaction is outstanding at a time.

Parameters:
- TIMEOUT, 1024: cycles allowed in response states before a timeout is declared.
- LEN_BYTES, 8: payload byte count per transaction (fixed 64-bit word).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer happens when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  device address byte.
- req_wdata  in  64  write payload.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  64  read data, valid with rsp_valid.
- rsp_err  out  2  0 = ok, 1 = device status error, 2 = protocol error, 3 = timeout.
- noc_to_dev_ctl  out  1  1 = command/NOP byte, 0 = payload byte.
- noc_to_dev_data  out  8  outbound byte.
- noc_from_dev_ctl  in  1  inbound control flag.
- noc_from_dev_data  in  8  inbound byte.

Behaviour:
- Byte format: command byte has ctl=1 and data = {opcode[2:0], 3'b000, status[1:0]}. NOP = ctl 1, data 0x00. Payload bytes have ctl=0.
- Opcodes: 001 read, 010 write, 011 read response, 100 write response, 000 NOP.
- Reset (asynchronous, mid-packet included): state returns to IDLE and the packet is abandoned with no rsp_valid. Outputs take these values immediately: noc_to_dev_ctl=1, noc_to_dev_data=0x00, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, timeout counter=0.
- All NoC outputs are registered. When no byte is being sent, the block drives NOP.
- Write request accepted in cycle N. It emits one byte per cycle:
  - N+1: 0x40 (ctl 1).
  - N+2: addr (ctl 0).
  - N+3: 0x08 (ctl 0).
  - N+4..N+11: wdata[7:0] first, up to wdata[63:56] last (ctl 0).
  - Then enters WAIT_RSP.
- Read request accepted in cycle N:
  - N+1: 0x20.
  - N+2: addr.
  - N+3: 0x08.
  - Then enters WAIT_RSP.
- States: IDLE, TX_CMD, TX_ADDR, TX_LEN, TX_DATA (3-bit byte counter 0..7, wraps to exit), WAIT_RSP, RX_LEN, RX_DATA (3-bit counter), DONE.
- WAIT_RSP:
  - ctl=0 bytes are ignored.
  - ctl=1 with opcode 000 is ignored.
  - Expected opcode (100 after a write, 011 after a read) is accepted.
  - Any other ctl=1 byte causes DONE with err=2.
- Write response: captured status != 0 gives err=1, otherwise err=0. Go to DONE.
- Read response path:
  - RX_LEN expects a ctl=0 byte equal to 8. Any other value causes DONE with err=2.
  - RX_DATA assembles 8 ctl=0 bytes LSB-first into rsp_rdata.
  - A ctl=1 byte arriving in RX_LEN or RX_DATA is a truncated packet: DONE with err=2. That byte is not reinterpreted.
  - After the 8th byte, err = (status != 0) ? 1 : 0.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_ready rises in the cycle after the rsp_valid pulse.
- rsp_rdata holds its value until the next read completes. Writes and error completions leave rsp_rdata unchanged, except that a truncated read updates only the bytes already received.
- Timeout:
  - The counter clears on entry to WAIT_RSP and increments every cycle in WAIT_RSP, RX_LEN and RX_DATA.
  - When the count reaches TIMEOUT-1 without completion: DONE with err=3.
  - Bytes arriving in that same cycle are ignored.
- Inbound bytes arriving while in IDLE or TX_* states are ignored; there is no buffering.
- req_valid deasserting while not ready has no effect. Request fields are sampled only on acceptance.

Test Plan:
- Write addr 0x05, data 0x8877665544332211 -> noc_to_dev bytes over 11 cycles: 40(c1) 05 08 11 22 33 44 55 66 77 88 (c0), then NOP. Device returns 0x80 -> rsp_valid pulse with rsp_err=0, and req_ready back high the next cycle.
- Read addr 0x12; device sends NOP, NOP, 0x60(c1), 08, then bytes EF BE AD DE 78 56 34 12 -> rsp_rdata=0x12345678DEADBEEF, rsp_err=0.
- Read; device returns 0x61, 08, 8 bytes -> rsp_err=1 with data captured. A write response of 0x82 -> rsp_err=1.
- Protocol errors -> rsp_err=2 in each case:
  - Read answered with 0x80.
  - Length byte 0x04.
  - 0x60 arriving mid-data after 3 bytes.
- TIMEOUT=16; read with the device silent (NOPs only) -> rsp_valid with rsp_err=3 exactly 16 cycles after WAIT_RSP entry.
- Assert reset during TX_DATA byte 4 -> outputs immediately ctl=1/0x00, no rsp_valid, req_ready=1. A new write after release produces a clean, full 11-byte packet.
